// File: rtl/wb_arbiter_2m_if.sv
// Wishbone-style port bundle shared by the two-master arbiter.
//   master modport : drives cyc/stb/we/addr/width/data_write, receives data_read/ack/err
//   slave modport  : the mirror image
// err is part of the bundle so the same type serves both sides of the arbiter;
// the RAM slave does not use it.
interface wb_arbiter_2m_if #(
    parameter int ADDR_W = 32
) ();
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        width;
    logic [31:0]       data_write;
    logic [31:0]       data_read;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, addr, width, data_write,
        input  data_read, ack, err
    );

    modport slave (
        input  cyc, stb, we, addr, width, data_write,
        output data_read, ack, err
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with round-robin fairness and a
// per-strobe ack watchdog. Master 0 is instruction fetch, master 1 is
// load/store, the slave is the shared on-chip RAM.
//   iClk   : system clock, rising edge
//   iRst   : synchronous active-high reset
//   m0, m1 : master-facing ports (slave modport of the bundle)
//   s      : RAM-facing port (master modport of the bundle)
// Whole bus cycles are granted; a grant lasts while the owner holds cyc.
//
// state | meaning
// IDLE  | no grant; all outputs 0; arbitration on cyc
// GNT0  | master 0 owns the slave
// GNT1  | master 1 owns the slave
module wb_arbiter_2m #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic           iClk,
    input  logic           iRst,
    wb_arbiter_2m_if.slave  m0,
    wb_arbiter_2m_if.slave  m1,
    wb_arbiter_2m_if.master s
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [7:0] WDT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [7:0]        wdt_q, wdt_d;

    logic              g_cyc, g_stb, g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [1:0]        g_width;
    logic [31:0]       g_data_write;
    logic              waiting;
    logic              timeout;
    logic              unused_s_err;

    assign unused_s_err = s.err;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdt_q   <= wdt_d;
        end
    end

    // Next state. Leaving a grant always passes through IDLE, which is the
    // point where the other master gets its turn.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0.cyc) begin
                    state_d = GNT0;
                end else if (m1.cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0.cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT1: begin
                if (!m1.cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request mux toward the slave.
    always_comb begin
        g_cyc        = 1'b0;
        g_stb        = 1'b0;
        g_we         = 1'b0;
        g_addr       = '0;
        g_width      = '0;
        g_data_write = '0;
        if (state_q == GNT0) begin
            g_cyc        = m0.cyc;
            g_stb        = m0.stb;
            g_we         = m0.we;
            g_addr       = m0.addr;
            g_width      = m0.width;
            g_data_write = m0.data_write;
        end else if (state_q == GNT1) begin
            g_cyc        = m1.cyc;
            g_stb        = m1.stb;
            g_we         = m1.we;
            g_addr       = m1.addr;
            g_width      = m1.width;
            g_data_write = m1.data_write;
        end
    end

    assign s.cyc        = g_cyc;
    assign s.stb        = g_stb;
    assign s.we         = g_we;
    assign s.addr       = g_addr;
    assign s.width      = g_width;
    assign s.data_write = g_data_write;

    // Watchdog: counts strobe cycles without ack; an ack in the last cycle
    // wins over the timeout because waiting already requires !ack.
    always_comb begin
        waiting = g_cyc && g_stb && !s.ack;
        timeout = waiting && (wdt_q == WDT_LAST);
        wdt_d   = '0;
        if (waiting && !timeout) begin
            wdt_d = wdt_q + 8'd1;
        end
    end

    // Response demux. Responses are suppressed while reset is asserted so an
    // aborted grant never hands the owner a late ack or err.
    always_comb begin
        m0.data_read = '0;
        m0.ack       = 1'b0;
        m0.err       = 1'b0;
        m1.data_read = '0;
        m1.ack       = 1'b0;
        m1.err       = 1'b0;
        if (state_q == GNT0) begin
            m0.data_read = s.data_read;
            m0.ack       = s.ack && !iRst;
            m0.err       = timeout && !iRst;
        end else if (state_q == GNT1) begin
            m1.data_read = s.data_read;
            m1.ack       = s.ack && !iRst;
            m1.err       = timeout && !iRst;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
module tb_wb_arbiter_2m;

    logic iClk = 1'b0;
    logic iRst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    wb_arbiter_2m_if #(.ADDR_W(32)) m0_if ();
    wb_arbiter_2m_if #(.ADDR_W(32)) m1_if ();
    wb_arbiter_2m_if #(.ADDR_W(32)) s_if ();

    wb_arbiter_2m #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .m0   (m0_if.slave),
        .m1   (m1_if.slave),
        .s    (s_if.master)
    );

    always #5 iClk = ~iClk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, got running required finished");
        $fatal(1, "time limit");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic early;

        m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.addr = 32'h10;
        m0_if.width = 2'b10; m0_if.data_write = 32'h0;
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 1; m1_if.addr = 32'h20;
        m1_if.width = 2'b01; m1_if.data_write = 32'h12345678;
        s_if.data_read = 32'h0; s_if.ack = 0; s_if.err = 0;

        // reset
        step(); step();
        iRst = 0;
        settle();
        check_val("rst_s_cyc", s_if.cyc, 0);
        check_val("rst_s_stb", s_if.stb, 0);
        check_val("rst_m0_ack", m0_if.ack, 0);
        check_val("rst_m1_err", m1_if.err, 0);

        // m0 read alone
        m0_if.cyc = 1; m0_if.stb = 1;
        settle();
        check_val("t1_latency_stb", s_if.stb, 0);
        step();
        s_if.ack = 1; s_if.data_read = 32'hDEADBEEF;
        settle();
        check_val("t1_s_stb", s_if.stb, 1);
        check_val("t1_s_addr", s_if.addr, 32'h10);
        check_val("t1_s_width", s_if.width, 2'b10);
        check_val("t1_m0_ack", m0_if.ack, 1);
        check_val("t1_m0_data", m0_if.data_read, 32'hDEADBEEF);
        check_val("t1_m1_ack", m1_if.ack, 0);
        check_val("t1_m1_data", m1_if.data_read, 0);
        m0_if.cyc = 0; m0_if.stb = 0; s_if.ack = 0; s_if.data_read = 0;
        step();
        check_val("t1_idle", s_if.cyc, 0);

        // simultaneous first request after reset -> master 0
        iRst = 1;
        step();
        iRst = 0;
        m0_if.cyc = 1; m0_if.stb = 1; m1_if.cyc = 1; m1_if.stb = 1;
        step();
        s_if.ack = 1;
        settle();
        check_val("t2_first_addr", s_if.addr, 32'h10);
        check_val("t2_first_we", s_if.we, 0);
        check_val("t2_m0_ack", m0_if.ack, 1);
        check_val("t2_m1_ack", m1_if.ack, 0);
        s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
        step();
        check_val("t2_gap", s_if.cyc, 0);
        step();
        check_val("t2_second_cyc", s_if.cyc, 1);
        check_val("t2_second_addr", s_if.addr, 32'h20);
        check_val("t2_second_we", s_if.we, 1);
        check_val("t2_second_wdata", s_if.data_write, 32'h12345678);
        check_val("t2_second_width", s_if.width, 2'b01);
        m1_if.cyc = 0; m1_if.stb = 0;
        step();

        // round robin, both masters keep requesting; last served = 1
        m0_if.cyc = 1; m0_if.stb = 1; m1_if.cyc = 1; m1_if.stb = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val($sformatf("t3_grant%0d_addr", k), s_if.addr,
                      (k % 2 == 0) ? 64'h10 : 64'h20);
            check_val($sformatf("t3_grant%0d_cyc", k), s_if.cyc, 1);
            if (k % 2 == 0) begin m0_if.cyc = 0; m0_if.stb = 0; end
            else            begin m1_if.cyc = 0; m1_if.stb = 0; end
            step();
            check_val($sformatf("t3_gap%0d", k), s_if.cyc, 0);
            if (k % 2 == 0) begin m0_if.cyc = 1; m0_if.stb = 1; end
            else            begin m1_if.cyc = 1; m1_if.stb = 1; end
        end
        m0_if.cyc = 0; m0_if.stb = 0; m1_if.cyc = 0; m1_if.stb = 0;
        step();

        // timeout: m1 writes, slave silent; err on 16th strobe cycle
        m1_if.cyc = 1; m1_if.stb = 1;
        step();
        early = 0;
        for (int i = 1; i <= 15; i++) begin
            if (m1_if.err !== 1'b0) early = 1;
            step();
        end
        check_val("t4_no_early_err", early, 0);
        check_val("t4_err", m1_if.err, 1);
        check_val("t4_ack", m1_if.ack, 0);
        check_val("t4_m0_err", m0_if.err, 0);
        step();
        check_val("t4_err_pulse", m1_if.err, 0);
        check_val("t4_grant_held", s_if.cyc, 1);
        check_val("t4_grant_addr", s_if.addr, 32'h20);
        m1_if.cyc = 0; m1_if.stb = 0;
        step();
        check_val("t4_release", s_if.cyc, 0);

        // ack exactly on the timeout cycle
        m1_if.cyc = 1; m1_if.stb = 1;
        step();
        for (int i = 1; i <= 15; i++) step();
        s_if.ack = 1;
        settle();
        check_val("t5_ack", m1_if.ack, 1);
        check_val("t5_no_err", m1_if.err, 0);
        s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0;
        step();

        // one m0 transaction so last served = 0
        m0_if.cyc = 1; m0_if.stb = 1;
        step();
        check_val("t6_pre_addr", s_if.addr, 32'h10);
        m0_if.cyc = 0; m0_if.stb = 0;
        step();

        // reset mid-cycle while m0 holds a strobe
        m0_if.cyc = 1; m0_if.stb = 1;
        step();
        check_val("t6_gnt0_stb", s_if.stb, 1);
        iRst = 1;
        step();
        iRst = 0;
        s_if.ack = 1;
        m1_if.cyc = 1; m1_if.stb = 1;
        settle();
        check_val("t6_s_cyc", s_if.cyc, 0);
        check_val("t6_s_stb", s_if.stb, 0);
        check_val("t6_m0_ack", m0_if.ack, 0);
        check_val("t6_m0_err", m0_if.err, 0);
        s_if.ack = 0;
        step();
        check_val("t6_regrant_addr", s_if.addr, 32'h10);
        check_val("t6_regrant_cyc", s_if.cyc, 1);
        m0_if.cyc = 0; m0_if.stb = 0; m1_if.cyc = 0; m1_if.stb = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
